// File: rtl/pn_buf_ctrl.sv
// pn_buf_ctrl: ownership controller for an N-slot packet buffer pool.
// Slots rotate snooper -> CPU -> forwarder -> free; per-slot lengths and accept/reject stats are kept.
module pn_buf_ctrl #(
   parameter int N_SLOTS    = 4,
   parameter int SLOT_W     = $clog2(N_SLOTS),
   parameter int INC_WIDTH  = 8,
   parameter int PLEN_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sn_wr_en,
   input  logic [INC_WIDTH-1:0]  sn_byte_inc,
   input  logic                  sn_done,
   output logic                  rdy_for_sn,
   input  logic                  rdy_for_sn_ack,
   output logic [SLOT_W-1:0]     sn_sel,
   input  logic                  cpu_acc,
   input  logic                  cpu_rej,
   output logic                  rdy_for_cpu,
   input  logic                  rdy_for_cpu_ack,
   output logic [SLOT_W-1:0]     cpu_sel,
   output logic [PLEN_WIDTH-1:0] cpu_byte_len,
   input  logic                  fwd_done,
   output logic                  rdy_for_fwd,
   input  logic                  rdy_for_fwd_ack,
   output logic [SLOT_W-1:0]     fwd_sel,
   output logic [PLEN_WIDTH-1:0] fwd_byte_len,
   output logic [CNT_WIDTH-1:0]  acc_cnt,
   output logic [CNT_WIDTH-1:0]  rej_cnt,
   output logic [SLOT_W:0]       occupancy
);
   typedef enum logic [2:0] {
      ST_FREE, ST_SN, ST_FILLED, ST_CPU, ST_ACC, ST_FWD
   } slot_state_t;

   slot_state_t           state_reg  [N_SLOTS];
   slot_state_t           state_next [N_SLOTS];
   logic [PLEN_WIDTH-1:0] len_reg    [N_SLOTS];
   logic [SLOT_W-1:0]     cq_mem     [N_SLOTS];
   logic [SLOT_W-1:0]     fq_mem     [N_SLOTS];
   logic [SLOT_W-1:0]     cq_rd, cq_wr, fq_rd, fq_wr;
   logic [SLOT_W:0]       cq_cnt, fq_cnt, cq_cnt_next, fq_cnt_next, occ_next;
   logic                  sn_busy, cpu_busy, fwd_busy;
   logic [N_SLOTS-1:0]    slot_free;
   logic                  free_any, free_any_next;
   logic [SLOT_W-1:0]     free_idx;
   logic                  sn_claim, sn_rel, cpu_claim, cpu_accept, cpu_reject, fwd_claim, fwd_rel;

   function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
      return (p == SLOT_W'(N_SLOTS - 1)) ? '0 : p + SLOT_W'(1);
   endfunction

   for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_free
      assign slot_free[gi] = (state_reg[gi] == ST_FREE);
   end

   // Downward scan so the lowest free index wins.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (slot_free[i]) begin
            free_any = 1'b1;
            free_idx = SLOT_W'(i);
         end
      end
   end

   // A registered rdy already implies the agent is idle.
   assign sn_claim   = rdy_for_sn  & rdy_for_sn_ack  & free_any;
   assign sn_rel     = sn_busy  & sn_done;
   assign cpu_claim  = rdy_for_cpu & rdy_for_cpu_ack & (cq_cnt != '0);
   assign cpu_accept = cpu_busy & cpu_acc;
   assign cpu_reject = cpu_busy & cpu_rej & ~cpu_acc;
   assign fwd_claim  = rdy_for_fwd & rdy_for_fwd_ack & (fq_cnt != '0);
   assign fwd_rel    = fwd_busy & fwd_done;

   assign cq_cnt_next = cq_cnt + (SLOT_W+1)'(sn_rel) - (SLOT_W+1)'(cpu_claim);
   assign fq_cnt_next = fq_cnt + (SLOT_W+1)'(cpu_accept) - (SLOT_W+1)'(fwd_claim);

   assign cpu_byte_len = cpu_busy ? len_reg[cpu_sel] : '0;
   assign fwd_byte_len = fwd_busy ? len_reg[fwd_sel] : '0;

   // Releases are applied after claims so they take precedence on the same slot.
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) state_next[i] = state_reg[i];
      if (sn_claim)   state_next[free_idx]     = ST_SN;
      if (cpu_claim)  state_next[cq_mem[cq_rd]] = ST_CPU;
      if (fwd_claim)  state_next[fq_mem[fq_rd]] = ST_FWD;
      if (sn_rel)     state_next[sn_sel]  = ST_FILLED;
      if (cpu_accept) state_next[cpu_sel] = ST_ACC;
      if (cpu_reject) state_next[cpu_sel] = ST_FREE;
      if (fwd_rel)    state_next[fwd_sel] = ST_FREE;
      free_any_next = 1'b0;
      occ_next      = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (state_next[i] == ST_FREE) free_any_next = 1'b1;
         else                          occ_next = occ_next + (SLOT_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            state_reg[i] <= ST_FREE;
            len_reg[i]   <= '0;
            cq_mem[i]    <= '0;
            fq_mem[i]    <= '0;
         end
         cq_rd       <= '0;
         cq_wr       <= '0;
         fq_rd       <= '0;
         fq_wr       <= '0;
         cq_cnt      <= '0;
         fq_cnt      <= '0;
         sn_busy     <= 1'b0;
         cpu_busy    <= 1'b0;
         fwd_busy    <= 1'b0;
         sn_sel      <= '0;
         cpu_sel     <= '0;
         fwd_sel     <= '0;
         rdy_for_sn  <= 1'b0;
         rdy_for_cpu <= 1'b0;
         rdy_for_fwd <= 1'b0;
         acc_cnt     <= '0;
         rej_cnt     <= '0;
         occupancy   <= '0;
      end else begin
         for (int i = 0; i < N_SLOTS; i++) state_reg[i] <= state_next[i];

         if (sn_claim) begin
            sn_busy           <= 1'b1;
            sn_sel            <= free_idx;
            len_reg[free_idx] <= '0;
         end else if (sn_busy && sn_wr_en) begin
            len_reg[sn_sel] <= len_reg[sn_sel] + PLEN_WIDTH'(sn_byte_inc);
         end
         if (sn_rel) begin
            sn_busy       <= 1'b0;
            cq_mem[cq_wr] <= sn_sel;
            cq_wr         <= ptr_inc(cq_wr);
         end

         if (cpu_claim) begin
            cpu_busy <= 1'b1;
            cpu_sel  <= cq_mem[cq_rd];
            cq_rd    <= ptr_inc(cq_rd);
         end
         if (cpu_accept || cpu_reject) cpu_busy <= 1'b0;
         if (cpu_accept) begin
            fq_mem[fq_wr] <= cpu_sel;
            fq_wr         <= ptr_inc(fq_wr);
            if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
         end
         if (cpu_reject && rej_cnt != '1) rej_cnt <= rej_cnt + CNT_WIDTH'(1);

         if (fwd_claim) begin
            fwd_busy <= 1'b1;
            fwd_sel  <= fq_mem[fq_rd];
            fq_rd    <= ptr_inc(fq_rd);
         end
         if (fwd_rel) fwd_busy <= 1'b0;

         cq_cnt    <= cq_cnt_next;
         fq_cnt    <= fq_cnt_next;
         occupancy <= occ_next;

         // Agent must have been idle this cycle, so a finishing agent waits one extra edge.
         rdy_for_sn  <= ~sn_busy  & ~sn_claim  & free_any_next;
         rdy_for_cpu <= ~cpu_busy & ~cpu_claim & (cq_cnt_next != '0);
         rdy_for_fwd <= ~fwd_busy & ~fwd_claim & (fq_cnt_next != '0);
      end
   end
endmodule

// File: doc/pn_buf_ctrl.md
# pn_buf_ctrl

Ownership controller for an N-slot packet buffer pool inside a packetfilter core. It is the parametrised successor to the fixed three-buffer ping-pong scheme, with N_SLOTS buffers rotating between snooper, CPU and forwarder. It:
- hands out free slots to the snooper;
- queues filled slots to the CPU in fill order;
- queues accepted slots to the forwarder in accept order;
- returns rejected and forwarded slots to the free pool.

It also tracks per-slot byte lengths and accept/reject statistics.

## Interface
- N_SLOTS, 4: buffer slot count, 2..16.
- SLOT_W, $clog2(N_SLOTS): slot index width.
- INC_WIDTH, 8: width of snooper byte increment.
- PLEN_WIDTH, 32: packet byte-length width.
- CNT_WIDTH, 16: statistics counter width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sn_wr_en  in  1  snooper write strobe, qualifies sn_byte_inc.
- sn_byte_inc  in  INC_WIDTH  bytes added by this write.
- sn_done  in  1  snooper finished current packet.
- rdy_for_sn  out  1  a free slot is available to claim.
- rdy_for_sn_ack  in  1  snooper claims the offered slot.
- sn_sel  out  SLOT_W  slot owned by snooper.
- cpu_acc  in  1  CPU accepts current packet.
- cpu_rej  in  1  CPU rejects current packet.
- rdy_for_cpu  out  1  a filled slot is available.
- rdy_for_cpu_ack  in  1  CPU claims it.
- cpu_sel  out  SLOT_W  slot owned by CPU.
- cpu_byte_len  out  PLEN_WIDTH  length of CPU's slot, 0 when CPU idle.
- fwd_done  in  1  forwarder finished current packet.
- rdy_for_fwd  out  1  an accepted slot is available.
- rdy_for_fwd_ack  in  1  forwarder claims it.
- fwd_sel  out  SLOT_W  slot owned by forwarder.
- fwd_byte_len  out  PLEN_WIDTH  length of forwarder's slot, 0 when idle.
- acc_cnt  out  CNT_WIDTH  accepted packets, saturating.
- rej_cnt  out  CNT_WIDTH  rejected packets, saturating.
- occupancy  out  SLOT_W+1  number of non-FREE slots.

## Operation
- Per-slot state: FREE → SN → FILLED → CPU → ACCEPTED → FWD → FREE. CPU → FREE on reject.
- Each agent (sn, cpu, fwd) has a busy flag and holds at most one slot.
- Snooper claim takes the lowest-index FREE slot; that slot's length register is cleared to 0.
- While sn busy and sn_wr_en: len[sn_sel] += sn_byte_inc, zero-extended, wrapping modulo 2^PLEN_WIDTH. Writes while not busy are ignored.
- sn_done while busy: slot → FILLED, index pushed to the cpu FIFO (depth N_SLOTS), snooper idle.
- CPU claim pops the cpu FIFO head.
- cpu_acc while busy: slot → ACCEPTED, pushed to the fwd FIFO (depth N_SLOTS), acc_cnt++.
- cpu_rej while busy: slot → FREE, rej_cnt++.
- acc and rej asserted together: acc wins, rej ignored.
- fwd claim pops the fwd FIFO head. fwd_done while busy: slot → FREE.
- Done/acc/rej while the agent is idle are ignored.
- Acks while the matching rdy is low are ignored.
- FIFOs never overflow: slot count bounds total occupancy.
- Counters saturate at all-ones.

## Timing
- rdy_for_sn, rdy_for_cpu and rdy_for_fwd are registered outputs. Each is high iff the agent is idle and a candidate exists (free slot / non-empty FIFO), evaluated on the current-cycle state.
- Ack at edge t: the agent is busy from t, X_sel is valid after t, and rdy_X is low after t.
- Done/acc/rej at edge t: the agent is idle after t, and rdy_X may re-assert no earlier than after edge t+1. There is a minimum one idle cycle between packets per agent.
- A slot released at edge t is visible as a candidate after t. The earliest claim by the next agent is at edge t+1.
  - Example: sn_done and rdy_for_cpu_ack in the same cycle with an empty cpu FIFO → the ack is ignored.
- cpu_byte_len and fwd_byte_len are combinational muxes of registered lengths. Lengths are frozen once the slot leaves SN.
- occupancy updates the cycle after any claim/release.
  - A simultaneous claim and release nets out.
  - Release wins for same-slot bookkeeping because a slot cannot be in two states.
- Reset (rst low, asynchronous), at any time including mid-packet:
  - all slots FREE, FIFOs empty, busy flags clear;
  - all rdy outputs, sel outputs, length registers, counters and occupancy are 0.
- rdy_for_sn rises at the first edge after rst deasserts.

## Test plan
- Reset release, N_SLOTS=4 → all outputs 0. rdy_for_sn=1 after the first edge; rdy_for_cpu=rdy_for_fwd=0.
- Snooper claims, writes increments 8,8,8,3 with sn_wr_en, then sn_done:
  - sn_sel=0;
  - rdy_for_cpu=1 two edges later;
  - after CPU claim, cpu_sel=0 and cpu_byte_len=27.
- Fill slots 0,1,2,3 without the CPU claiming → occupancy=4 and rdy_for_sn=0. CPU then claims three times, rejecting each → cpu_sel sequence 0,1,2, rej_cnt=3, rdy_for_sn re-asserts.
- CPU accepts slots in order 2,0 → forwarder claims fwd_sel=2 then 0, with fwd_byte_len matching the lengths written. fwd_done frees them and occupancy decrements.
- cpu_acc and cpu_rej in the same cycle → acc_cnt+1, rej_cnt unchanged, slot enters the fwd FIFO. rdy_for_cpu_ack while rdy_for_cpu=0 → no state change.
- Assert rst mid-packet (sn busy, CPU busy, one slot in fwd FIFO) → all outputs 0 immediately, and normal operation after release starts from slot 0.
- CNT_WIDTH=4 with 17 accepts → acc_cnt holds at 15.
